mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port 32x8 program/data RAM between two requesters: the CPU datapath (MAR/MBR side) and the external boot-load/debug port.
- Sits between those two requesters and the memory macro.
- Issues at most one access per cycle and returns read data with a fixed 1-cycle latency.
- Uses round-robin fairness on contention and keeps per-requester access counters for debug display.

Parameters:
- ADDR_W, 5, memory address width (32 words).
- DATA_W, 8, memory data width.
- CNT_W, 8, width of the saturating per-requester access counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_rvalid  out  1  CPU read data valid this cycle.
- ldr_req  in  1  loader access request; held until ldr_gnt.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_lock  in  1  loader exclusive-ownership request (see Optional Feature).
- ldr_gnt  out  1  loader access issued this cycle.
- ldr_rvalid  out  1  loader read data valid this cycle.
- rdata  out  DATA_W  read data, shared by both requesters, qualified by the rvalid outputs.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous RAM read data, valid 1 cycle after mem_en with mem_we=0.
- cpu_cnt  out  CNT_W  count of granted CPU accesses.
- ldr_cnt  out  CNT_W  count of granted loader accesses.

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0;
  - last_owner = LDR, so the CPU wins the first contention;
  - counters 0;
  - read pipeline cleared;
  - state = ARB_RR.
- Grant is combinational from the requests and registered state. When granted in cycle N:
  - mem_en=1 in cycle N;
  - mem_we, mem_addr and mem_wdata are taken from the winner in cycle N;
  - the winner's gnt=1 in cycle N only.
- Requesters hold req and payload stable until gnt; a request dropped before gnt is legal and simply abandoned.
- Arbitration in ARB_RR:
  - one request → grant it;
  - both requests → grant the requester that is not last_owner;
  - last_owner updates on every grant.
- Throughput: one access per cycle; back-to-back grants to the same requester are allowed when the other is idle.
- Read return:
  - rd_pend and rd_owner are registered on a granted read;
  - cycle N+1: rdata = mem_rdata and the matching rvalid = 1;
  - a write produces no rvalid;
  - rvalid and a new gnt may coincide.
- No requests → mem_en=0, mem_addr/mem_wdata hold their last value, and state is unchanged.
- Counters:
  - increment by 1 on the owner's gnt;
  - saturate at 2^CNT_W-1, no wrap.
- Reset mid-read: the pending rvalid is discarded and never emitted after reset release.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Loader is granted while ldr_lock=1 → state moves to ARB_LOCKED.
  - In ARB_LOCKED only the loader is granted; cpu_gnt=0 even if cpu_req=1.
  - ldr_lock=0 → state returns to ARB_RR on the next edge, with last_owner = LDR.
  - ldr_lock asserted while the CPU holds the current grant → takes effect from the loader's next grant.
- Undefined:
  - ldr_lock is ignored (port retained, unused);
  - the FSM has only ARB_RR.

Decomposition:
- Shared package: owner encoding (OWN_CPU=0, OWN_LDR=1), state encoding (ARB_RR, ARB_LOCKED), ADDR_W/DATA_W defaults.
- One natural sub-module: sat_counter (CNT_W-bit saturating incrementer, async active-low clear), instantiated twice.

Test Plan:
- Reset release, cpu_req read addr 5 with mem[5]=0x3C → cpu_gnt and mem_en in the same cycle; next cycle cpu_rvalid=1, rdata=0x3C, ldr_rvalid=0.
- cpu_req and ldr_req both held for 4 cycles → grants alternate CPU, LDR, CPU, LDR; cpu_cnt=2, ldr_cnt=2.
- Loader writes 0xA5 to addr 31, then CPU reads addr 31 next cycle → cpu_rvalid with rdata=0xA5; no rvalid for the write.
- cpu_req continuous for 300 cycles, no loader traffic → cpu_cnt saturates at 255.
- Assert reset during the cycle after a CPU read grant → no cpu_rvalid after release; counters=0; first contention goes to CPU.
- ARB_LOCK_EN defined: ldr_lock=1 with both requesting for 3 cycles → ldr_gnt every cycle, cpu_gnt=0. Drop ldr_lock → next contended grant goes to CPU.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter.
// Owner/state encodings and default widths.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DFLT = 5;
  localparam int DATA_W_DFLT = 8;
  localparam int CNT_W_DFLT  = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  typedef enum logic {
    ARB_RR     = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// sat_counter: CNT_W-bit incrementer that sticks at all-ones.
// Ports: clk, rst_n (async clear), inc, count.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + One;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32x8 sync RAM between CPU and loader.
// Ports: cpu_*/ldr_* requesters, mem_* macro side, rdata/rvalid return,
// cpu_cnt/ldr_cnt debug counters. Macro ARB_LOCK_EN adds loader lock.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int CNT_W  = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  cpu_cnt,
  output logic [CNT_W-1:0]  ldr_cnt
);

  arb_state_e        state;
  owner_e            lastOwner;
  owner_e            lastOwnerNxt;
  owner_e            rdOwner;
  logic              rdPend;
  logic              cpuWin;
  logic              ldrWin;
  logic              cpuBlock;
  logic              lockExit;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;

`ifdef ARB_LOCK_EN
  arb_state_e stateNxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_RR;
    end else begin
      state <= stateNxt;
    end
  end

  // Lock is only taken on a loader grant, so a lock raised while the
  // CPU is being served waits for the loader's next turn.
  always_comb begin
    stateNxt = state;
    lockExit = 1'b0;
    unique case (state)
      ARB_RR: begin
        if (ldrWin && ldr_lock) begin
          stateNxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (!ldr_lock) begin
          stateNxt = ARB_RR;
          lockExit = 1'b1;
        end
      end
      default: stateNxt = ARB_RR;
    endcase
  end
`else
  logic unusedLock;

  assign state      = ARB_RR;
  assign lockExit   = 1'b0;
  assign unusedLock = ldr_lock;
`endif

  assign cpuBlock = (state == ARB_LOCKED);

  // CPU wins when alone, or on contention when the loader went last.
  assign cpuWin = cpu_req && !cpuBlock &&
                  (!ldr_req || (lastOwner == OWN_LDR));
  assign ldrWin = ldr_req && !cpuWin;

  assign cpu_gnt = cpuWin;
  assign ldr_gnt = ldrWin;

  // Idle cycles replay the last address/data so the macro pins stay quiet.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addrQ;
    mem_wdata = wdataQ;
    unique case (1'b1)
      cpuWin: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      ldrWin: begin
        mem_en    = 1'b1;
        mem_we    = ldr_we;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    lastOwnerNxt = lastOwner;
    unique case (1'b1)
      cpuWin:   lastOwnerNxt = OWN_CPU;
      ldrWin:   lastOwnerNxt = OWN_LDR;
      lockExit: lastOwnerNxt = OWN_LDR;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastOwner <= OWN_LDR;
      rdPend    <= 1'b0;
      rdOwner   <= OWN_CPU;
      addrQ     <= '0;
      wdataQ    <= '0;
    end else begin
      lastOwner <= lastOwnerNxt;
      rdPend    <= mem_en && !mem_we;
      if (mem_en) begin
        rdOwner <= ldrWin ? OWN_LDR : OWN_CPU;
        addrQ   <= mem_addr;
        wdataQ  <= mem_wdata;
      end
    end
  end

  assign cpu_rvalid = rdPend && (rdOwner == OWN_CPU);
  assign ldr_rvalid = rdPend && (rdOwner == OWN_LDR);
  assign rdata      = rdPend ? mem_rdata : '0;

  sat_counter #(.CNT_W(CNT_W)) uCpuCnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (cpuWin),
    .count (cpu_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uLdrCnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (ldrWin),
    .count (ldr_cnt)
  );

endmodule
